gray_counter: RTL
=================

Name: gray_counter

Overview:
- Up/down counter whose registered output is Gray-coded.
- Sits directly upstream of gray_to_binary: its gray output drives the converter input. A typical use is a FIFO/pointer path that needs single-bit-change transitions.
- Internally counts in binary. The Gray value is a registered function of that count, so the output never glitches.
- Also provides a synchronous load of a Gray-coded value and a one-cycle wrap pulse.

Parameters:
- WIDTH, 4, counter and code width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when counting.
- load  input  1  synchronous load strobe.
- load_gray  input  WIDTH  Gray-coded value to load.
- gray  output  WIDTH  registered Gray count.
- bin  output  WIDTH  registered binary equivalent of gray; same cycle, same register stage.
- wrap  output  1  registered one-cycle pulse on counter roll-over.

Behaviour:
- Reset, evaluated at the rising edge when rst=1: gray=0, bin=0, wrap=0. rst overrides load and en. Reset mid-count takes effect on that edge, with no partial step.
- Priority per edge: rst > load > en > hold.
- Load (load=1, rst=0):
  - gray <= load_gray.
  - bin <= Gray-to-binary of load_gray, computed internally: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
  - wrap <= 0. en is ignored that cycle.
- Count (en=1, load=0, rst=0):
  - bin_next = bin+1 (up=1) or bin-1 (up=0), modulo 2^WIDTH.
  - gray <= bin_next ^ (bin_next>>1); bin <= bin_next.
- Hold (en=0, load=0): gray, bin unchanged; wrap <= 0.
- wrap <= 1 for exactly one cycle, only on these steps:
  - up=1 from bin=2^WIDTH-1 to 0.
  - up=0 from bin=0 to 2^WIDTH-1.
  - All other cycles, including loads, give wrap <= 0.
- Latency: output changes are visible one clock after the sampling edge of en/load; no combinational input-to-output path.
- Invariant: gray == bin ^ (bin>>1) after every edge, reset included.
- Invariant: each count step changes exactly one bit of gray. A load may change any number of bits.
- Direction change mid-run: takes effect on the first edge where the new up value is sampled with en=1. No dead cycle.
- Continuous en=1: the counter advances every cycle, with no stall states.
- Load of the current value: outputs unchanged and wrap=0.

Test Plan:
- Reset then up-count, WIDTH=4, rst 2 cycles then en=1, up=1 for 16 cycles:
  - gray = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - wrap=1 only on the cycle after 1000->0000.
  - Every step has Hamming distance 1.
- Down wrap: from reset, en=1, up=0 for 1 cycle -> gray=1000, bin=1111, wrap=1. Next cycle -> gray=1001, bin=1110, wrap=0.
- Load priority: load=1, load_gray=1101, en=1, up=1 on the same edge -> gray=1101, bin=1001, wrap=0. Next edge with en=1 -> gray=1111, bin=1010.
- Hold and direction change:
  - Count up to gray=0110 (bin=0100).
  - en=0 for 3 cycles -> gray stays 0110.
  - en=1, up=0 -> gray=0010 (bin=0011).
- Reset mid-operation: count to bin=1010, assert rst together with load=1, load_gray=1111 -> gray=0000, bin=0000, wrap=0.
- Downstream check: feed gray into gray_to_binary for a 32-cycle random en/up/load sequence -> converter output equals bin every cycle.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray and binary outputs, a synchronous
// Gray-coded load and a one-cycle wrap pulse on roll-over in either direction.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] step_bin;
  logic [WIDTH-1:0] next_bin;
  logic             next_wrap;

  // Binary bit i of a Gray word is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(load_gray >> i);
    end
  end

  always_comb begin
    step_bin  = up ? (bin + ONE) : (bin - ONE);
    next_bin  = bin;
    next_wrap = 1'b0;
    if (load) begin
      next_bin = load_bin;
    end else if (en) begin
      next_bin  = step_bin;
      next_wrap = up ? (bin == ALL_ONES) : (bin == '0);
    end
  end

  // Gray is derived from the same next-state binary so both outputs share one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= next_bin ^ (next_bin >> 1);
      wrap <= next_wrap;
    end
  end

endmodule
